// File: rtl/fft_out_reorder.sv
// fft_out_reorder: re-emits bit-reversed FFT frames in natural order through a ping-pong RAM; optional FFT_OUT_REORDER_BYPASS_EN adds bypass_en.
// Latency: 2 cycles from a frame's last input handshake to its first m_axis_tvalid, then 1 sample/cycle.
// Backpressure: s_axis_tready low while both banks hold undrained frames; RAM reads stall when the 2-entry skid would overflow.
module fft_out_reorder #(
    parameter int DATA_WDT     = 32,
    parameter int FFT_LEN_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_WDT-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [DATA_WDT-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                err_tlast,
`ifdef FFT_OUT_REORDER_BYPASS_EN
    input  logic                bypass_en,
`endif
    input  logic                err_clr
);
    localparam int N  = 1 << FFT_LEN_LOG2;
    localparam int AW = FFT_LEN_LOG2;
    localparam logic [AW-1:0] CNT_MAX = AW'(N - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_FLUSH} rd_state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    logic [DATA_WDT-1:0] mem [2*N];
    logic [DATA_WDT-1:0] ram_q;
    logic                ram_lst, rd_vld;
    logic [1:0]          bank_full, full_set, full_clr;
    logic                wr_bank, rd_bank;
    logic [AW-1:0]       wr_cnt, rd_cnt, wr_addr;
    logic                wr_hs, wr_last, rd_en, rd_release, pop, can_issue;
    logic [2:0]          occ;
    rd_state_t           state, state_nxt;

    logic [DATA_WDT-1:0] skid_dat [2];
    logic [1:0]          skid_lst;
    logic                skid_wp, skid_rp;
    logic [1:0]          skid_cnt;

    // ---------------- write side ----------------
    assign s_axis_tready = !bank_full[wr_bank];
    assign wr_hs         = s_axis_tvalid && s_axis_tready;
    assign wr_last       = (wr_cnt == CNT_MAX);

`ifdef FFT_OUT_REORDER_BYPASS_EN
    logic bypass_q, bypass_cur;
    // Word 0 uses the live pin; the rest of the frame uses the value captured there.
    assign bypass_cur = (wr_cnt == '0) ? bypass_en : bypass_q;
    assign wr_addr    = bypass_cur ? wr_cnt : bitrev(wr_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        bypass_q <= 1'b0;
        else if (wr_hs && wr_cnt == '0)    bypass_q <= bypass_en;
    end
`else
    assign wr_addr = bitrev(wr_cnt);
`endif

    assign full_set = (wr_hs && wr_last) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = rd_release ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            err_tlast <= 1'b0;
        end else begin
            // Banks differ whenever set and clear coincide, so both updates land.
            bank_full <= (bank_full & ~full_clr) | full_set;
            if (wr_hs) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            err_tlast <= (wr_hs && (s_axis_tlast != wr_last)) || (err_tlast && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hs) mem[{wr_bank, wr_addr}] <= s_axis_tdata;
        if (rd_en) ram_q <= mem[{rd_bank, rd_cnt}];
    end

    // ---------------- read side ----------------
    assign pop       = m_axis_tvalid && m_axis_tready;
    // Skid occupancy after this edge; the read issued now lands in the skid one edge later.
    assign occ       = {1'b0, skid_cnt} + {2'b00, rd_vld} - {2'b00, pop};
    assign can_issue = (occ <= 3'd1);

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        rd_release = 1'b0;
        case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank] && can_issue) begin
                    rd_en     = 1'b1;
                    state_nxt = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    if (rd_cnt == CNT_MAX) state_nxt = RD_FLUSH;
                end
            end
            RD_FLUSH: begin
                rd_release = 1'b1;
                state_nxt  = bank_full[~rd_bank] ? RD_STREAM : RD_IDLE;
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            rd_vld  <= 1'b0;
            ram_lst <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_cnt  <= rd_cnt + 1'b1;
                ram_lst <= (rd_cnt == CNT_MAX);
            end
            if (rd_release) rd_bank <= ~rd_bank;
        end
    end

    // ---------------- output skid ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_dat[0] <= '0;
            skid_dat[1] <= '0;
            skid_lst    <= 2'b00;
            skid_wp     <= 1'b0;
            skid_rp     <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            if (rd_vld) begin
                skid_dat[skid_wp] <= ram_q;
                skid_lst[skid_wp] <= ram_lst;
                skid_wp           <= ~skid_wp;
            end
            if (pop) skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

    assign m_axis_tvalid = (skid_cnt != 2'd0);
    assign m_axis_tdata  = skid_dat[skid_rp];
    assign m_axis_tlast  = m_axis_tvalid && skid_lst[skid_rp];

endmodule
